// File: rtl/uart_frame_check_if.sv
// ---------------------------------------------------------------------------
// uart_frame_check_if
//
// Bundles the signals exchanged between the UART RX sampler/host side and
// the frame checker. Clock and reset are not part of the bundle.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   CNT_WIDTH   width of each error counter (2..16)
//
// Signals (direction as seen from the checker, i.e. the slave modport):
//   frame_start  in   start bit validated, begin a new frame (1-cycle pulse)
//   bit_strb     in   sampled_bit holds the final sample of the current bit
//   sampled_bit  in   majority-sampled bit value
//   par_en       in   parity bit present (latched at frame_start)
//   par_typ      in   0 = even, 1 = odd (latched at frame_start)
//   stop2        in   0 = one stop bit, 1 = two stop bits (latched at frame_start)
//   err_clr      in   clear par_err / stp_err
//   cnt_clr      in   clear error counters
//   p_data       out  last good frame data
//   frame_done   out  frame finished, good or bad (1-cycle pulse)
//   frame_valid  out  frame finished with no error (1-cycle pulse)
//   par_err      out  parity error of last finished frame
//   stp_err      out  stop error of last finished frame
//   par_err_cnt  out  saturating parity error count
//   stp_err_cnt  out  saturating stop error count
// ---------------------------------------------------------------------------
interface uart_frame_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  frame_start;
    logic                  bit_strb;
    logic                  sampled_bit;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  err_clr;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  frame_done;
    logic                  frame_valid;
    logic                  par_err;
    logic                  stp_err;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;

    // Sampler / host side
    modport master (
        output frame_start, bit_strb, sampled_bit, par_en, par_typ, stop2,
               err_clr, cnt_clr,
        input  p_data, frame_done, frame_valid, par_err, stp_err,
               par_err_cnt, stp_err_cnt
    );

    // Frame checker side
    modport slave (
        input  frame_start, bit_strb, sampled_bit, par_en, par_typ, stop2,
               err_clr, cnt_clr,
        output p_data, frame_done, frame_valid, par_err, stp_err,
               par_err_cnt, stp_err_cnt
    );
endinterface

// File: rtl/uart_frame_check.sv
// ---------------------------------------------------------------------------
// uart_frame_check
//
// UART receive frame checker. Follows the RX sampler from the validated
// start bit onward: deserialises DATA_WIDTH data bits (LSB first), checks an
// optional even/odd parity bit and one or two stop bits, and reports
// per-frame error flags together with done / valid strobes.
//
// Optional feature (compile-time macro UART_FRAME_CHECK_ERR_CNT_EN):
//   defined     -> saturating parity / stop error counters with cnt_clr
//   not defined -> counters tied to 0, cnt_clr ignored
//
// Ports:
//   CLK   clock
//   RST   asynchronous, active-low reset
//   bus   uart_frame_check_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module uart_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_frame_check_if.slave    bus
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP1  = 3'd3,
        S_STOP2  = 3'd4
    } state_t;

    state_t                state_reg;
    logic [BCW-1:0]        bit_cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] p_data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic                  stop2_reg;
    logic                  run_par_reg;
    logic                  par_bad_reg;
    logic                  stp_bad_reg;
    logic                  par_err_reg;
    logic                  stp_err_reg;
    logic                  frame_done_reg;
    logic                  frame_valid_reg;

    // Finish happens on the strobe of the last stop bit. The stop fault of
    // that final bit is folded in combinationally so all frame results land
    // on the same edge. A concurrent frame_start aborts instead of finishing.
    logic finish_now;
    logic finish_stp;

    always_comb begin
        finish_now = 1'b0;
        finish_stp = stp_bad_reg;
        if (bus.bit_strb && !bus.frame_start) begin
            if ((state_reg == S_STOP1 && !stop2_reg) || state_reg == S_STOP2) begin
                finish_now = 1'b1;
                finish_stp = stp_bad_reg | ~bus.sampled_bit;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= S_IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            p_data_reg      <= '0;
            par_en_reg      <= 1'b0;
            par_typ_reg     <= 1'b0;
            stop2_reg       <= 1'b0;
            run_par_reg     <= 1'b0;
            par_bad_reg     <= 1'b0;
            stp_bad_reg     <= 1'b0;
            par_err_reg     <= 1'b0;
            stp_err_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            frame_done_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;

            if (bus.frame_start) begin
                // New frame (or abort-and-restart of the current one).
                par_en_reg  <= bus.par_en;
                par_typ_reg <= bus.par_typ;
                stop2_reg   <= bus.stop2;
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
                run_par_reg <= 1'b0;
                par_bad_reg <= 1'b0;
                stp_bad_reg <= 1'b0;
                par_err_reg <= 1'b0;
                stp_err_reg <= 1'b0;
                state_reg   <= S_DATA;
            end else begin
                if (bus.err_clr) begin
                    par_err_reg <= 1'b0;
                    stp_err_reg <= 1'b0;
                end

                case (state_reg)
                    S_IDLE: ;
                    S_DATA: begin
                        if (bus.bit_strb) begin
                            // LSB arrives first, so shifting in at the MSB
                            // leaves the word in natural order after the last bit.
                            shift_reg   <= {bus.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                            run_par_reg <= run_par_reg ^ bus.sampled_bit;
                            if (bit_cnt_reg == LAST_BIT) begin
                                state_reg <= par_en_reg ? S_PARITY : S_STOP1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bus.bit_strb) begin
                            par_bad_reg <= bus.sampled_bit ^ (run_par_reg ^ par_typ_reg);
                            state_reg   <= S_STOP1;
                        end
                    end
                    S_STOP1: begin
                        if (bus.bit_strb && stop2_reg) begin
                            stp_bad_reg <= stp_bad_reg | ~bus.sampled_bit;
                            state_reg   <= S_STOP2;
                        end
                    end
                    S_STOP2: ;
                    default: state_reg <= S_IDLE;
                endcase

                // Placed after err_clr so the frame result wins on a tie.
                if (finish_now) begin
                    par_err_reg     <= par_bad_reg;
                    stp_err_reg     <= finish_stp;
                    frame_done_reg  <= 1'b1;
                    frame_valid_reg <= ~par_bad_reg & ~finish_stp;
                    if (!par_bad_reg && !finish_stp) begin
                        p_data_reg <= shift_reg;
                    end
                    state_reg <= S_IDLE;
                end
            end
        end
    end

    assign bus.p_data      = p_data_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.par_err     = par_err_reg;
    assign bus.stp_err     = stp_err_reg;

`ifdef UART_FRAME_CHECK_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] par_cnt_reg;
    logic [CNT_WIDTH-1:0] stp_cnt_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_cnt_reg <= '0;
            stp_cnt_reg <= '0;
        end else if (bus.cnt_clr) begin
            par_cnt_reg <= '0;
            stp_cnt_reg <= '0;
        end else if (finish_now) begin
            if (par_bad_reg && par_cnt_reg != {CNT_WIDTH{1'b1}}) begin
                par_cnt_reg <= par_cnt_reg + 1'b1;
            end
            if (finish_stp && stp_cnt_reg != {CNT_WIDTH{1'b1}}) begin
                stp_cnt_reg <= stp_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.par_err_cnt = par_cnt_reg;
    assign bus.stp_err_cnt = stp_cnt_reg;
`else
    assign bus.par_err_cnt = '0;
    assign bus.stp_err_cnt = '0;
    wire unused_cnt_clr = bus.cnt_clr;
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
module tb_uart_frame_check;

    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_frame_check_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    uart_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: what the host should observe.
    logic [DW-1:0] m_pdata;
    logic          m_par;
    logic          m_stp;
    int            m_pcnt;
    int            m_scnt;

    typedef struct packed {
        logic [7:0] d;
        logic       pe, pt, s2, pb, b1, b2;
        logic       ev, epe, ese;
        logic [7:0] epd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int c);
`ifdef UART_FRAME_CHECK_ERR_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    // Counter rule in plain arithmetic: +1 per erroneous frame, capped.
    function automatic int bump(input int c, input logic e);
        if (e && c < CMAX) return c + 1;
        return c;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic b);
        bus.bit_strb    = 1'b1;
        bus.sampled_bit = b;
        cycle();
        bus.bit_strb    = 1'b0;
        bus.sampled_bit = 1'($urandom_range(0, 1));
    endtask

    // Drives one whole frame starting with frame_start; returns #1 after the
    // edge of the last stop strobe, i.e. while frame_done should be high.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic s2, input logic pb, input logic b1,
                              input logic b2, input logic clr_last,
                              input logic cclr_last, input int maxgap);
        logic bits [12];
        int   nb;
        int   early;
        logic e_par;
        logic e_stp;
        early = 0;
        nb    = 0;
        for (int i = 0; i < DW; i++) begin
            bits[nb] = d[i];
            nb++;
        end
        if (pe) begin
            bits[nb] = pb;
            nb++;
        end
        bits[nb] = b1;
        nb++;
        if (s2) begin
            bits[nb] = b2;
            nb++;
        end

        bus.frame_start = 1'b1;
        bus.par_en      = pe;
        bus.par_typ     = pt;
        bus.stop2       = s2;
        cycle();
        bus.frame_start = 1'b0;
        // Config wiggles mid-frame must be ignored.
        bus.par_en      = 1'($urandom_range(0, 1));
        bus.par_typ     = 1'($urandom_range(0, 1));
        bus.stop2       = 1'($urandom_range(0, 1));
        if (bus.frame_done) early++;

        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, maxgap)) begin
                cycle();
                if (bus.frame_done) early++;
            end
            if (i == nb - 1) begin
                bus.err_clr = clr_last;
                bus.cnt_clr = cclr_last;
            end
            strobe(bits[i]);
            bus.err_clr = 1'b0;
            bus.cnt_clr = 1'b0;
            if (i != nb - 1 && bus.frame_done) early++;
        end

        e_par = pe && (pb != ((^d) ^ pt));
        e_stp = !b1 || (s2 && !b2);
        m_par = e_par;
        m_stp = e_stp;
        if (!e_par && !e_stp) m_pdata = d;
        if (cclr_last) begin
            m_pcnt = 0;
            m_scnt = 0;
        end else begin
            m_pcnt = bump(m_pcnt, e_par);
            m_scnt = bump(m_scnt, e_stp);
        end

        chk("no_early_done", early, 0);
        chk("frame_done", bus.frame_done, 1);
        chk("frame_valid", bus.frame_valid, !(e_par || e_stp));
        chk("p_data", bus.p_data, m_pdata);
        chk("par_err", bus.par_err, m_par);
        chk("stp_err", bus.stp_err, m_stp);
        chk("par_err_cnt", bus.par_err_cnt, exp_cnt(m_pcnt));
        chk("stp_err_cnt", bus.stp_err_cnt, exp_cnt(m_scnt));
        $display("frame d=%02h pe=%0d pt=%0d s2=%0d pb=%0d stop=%0d%0d -> valid=%0d p_data=%02h perr=%0d serr=%0d pcnt=%0d scnt=%0d",
                 d, pe, pt, s2, pb, b1, b2, bus.frame_valid, bus.p_data,
                 bus.par_err, bus.stp_err, bus.par_err_cnt, bus.stp_err_cnt);
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        cycle();
        bus.err_clr = 1'b0;
        m_par = 1'b0;
        m_stp = 1'b0;
        chk("err_clr_par", bus.par_err, 0);
        chk("err_clr_stp", bus.stp_err, 0);
        chk("err_clr_no_done", bus.frame_done, 0);
        $display("err_clr -> perr=%0d serr=%0d", bus.par_err, bus.stp_err);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.bit_strb    = 1'b0;
        bus.sampled_bit = 1'b1;
        bus.par_en      = 1'b0;
        bus.par_typ     = 1'b0;
        bus.stop2       = 1'b0;
        bus.err_clr     = 1'b0;
        bus.cnt_clr     = 1'b0;
        m_pdata = '0;
        m_par   = 1'b0;
        m_stp   = 1'b0;
        m_pcnt  = 0;
        m_scnt  = 0;

        //            d      pe pt s2 pb b1 b2  ev epe ese epd
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
        tbl[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80};

        // Reset state
        repeat (3) cycle();
        chk("rst_p_data", bus.p_data, 0);
        chk("rst_par_err", bus.par_err, 0);
        chk("rst_stp_err", bus.stp_err, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_valid", bus.frame_valid, 0);
        chk("rst_pcnt", bus.par_err_cnt, 0);
        chk("rst_scnt", bus.stp_err_cnt, 0);
        RST = 1'b1;
        cycle();

        // Strobes in IDLE are ignored
        repeat (4) strobe(1'b0);
        chk("idle_no_done", bus.frame_done, 0);

        // Table of directed frames, sent back to back
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, tbl[i].s2, tbl[i].pb,
                       tbl[i].b1, tbl[i].b2, 1'b0, 1'b0, 1);
            chk("tbl_valid", bus.frame_valid, tbl[i].ev);
            chk("tbl_par_err", bus.par_err, tbl[i].epe);
            chk("tbl_stp_err", bus.stp_err, tbl[i].ese);
            chk("tbl_p_data", bus.p_data, tbl[i].epd);
        end
        cycle();
        chk("done_one_cycle", bus.frame_done, 0);
        chk("valid_one_cycle", bus.frame_valid, 0);

        // Abort after the 4th data strobe, then a full 0x3C frame
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
        for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1)));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("abort_p_data", bus.p_data, 8'h3C);

        // err_clr on the failing final stop strobe: finish result wins
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        chk("clr_tie_stp_err", bus.stp_err, 1);
        pulse_err_clr();

        // Flags hold across idle cycles
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (5) cycle();
        chk("hold_par_err", bus.par_err, m_par);

        // Reset mid-frame: outputs clear at once, no frame_done later
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
        for (int i = 0; i < 3; i++) strobe(1'b1);
        RST = 1'b0;
        #2;
        m_pdata = '0;
        m_par   = 1'b0;
        m_stp   = 1'b0;
        m_pcnt  = 0;
        m_scnt  = 0;
        chk("mid_rst_p_data", bus.p_data, 0);
        chk("mid_rst_par_err", bus.par_err, 0);
        chk("mid_rst_pcnt", bus.par_err_cnt, 0);
        chk("mid_rst_scnt", bus.stp_err_cnt, 0);
        cycle();
        RST = 1'b1;
        for (int i = 0; i < 10; i++) strobe(1'b1);
        chk("mid_rst_no_done", bus.frame_done, 0);
        $display("reset mid-frame -> p_data=%02h done=%0d", bus.p_data, bus.frame_done);

        // Counter saturation: five bad-stop frames
        for (int i = 0; i < 5; i++)
            send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        chk("sat_stp_cnt", bus.stp_err_cnt, exp_cnt(CMAX));
        // cnt_clr with a same-cycle bad frame
        send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        chk("cnt_clr_stp", bus.stp_err_cnt, 0);
        chk("cnt_clr_par", bus.par_err_cnt, 0);

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 2);
            if ($urandom_range(0, 3) == 0) begin
                cycle();
                pulse_err_clr();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_check.md
# uart_frame_check

Parametrised UART receive frame checker. It follows the RX sampler and tracks a whole frame from the validated start bit onward. It deserialises DATA_WIDTH data bits (LSB first), checks optional even/odd parity and one or two stop bits, and reports per-frame error flags plus a valid-data strobe to the RX FSM/host. Optionally it keeps saturating parity/stop error counters for link-quality monitoring.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- CNT_WIDTH, 8, width of each error counter (2..16)

- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- frame_start  in  1  1-cycle pulse: start bit validated, begin new frame
- bit_strb  in  1  1-cycle pulse: sampled_bit holds the final sample of the current bit
- sampled_bit  in  1  majority-sampled bit value
- par_en  in  1  parity bit present; latched at frame_start
- par_typ  in  1  0 = even, 1 = odd; latched at frame_start
- stop2  in  1  0 = one stop bit, 1 = two stop bits; latched at frame_start
- err_clr  in  1  clear par_err/stp_err
- cnt_clr  in  1  clear error counters
- p_data  out  DATA_WIDTH  last good frame data
- frame_done  out  1  1-cycle pulse: frame finished, good or bad
- frame_valid  out  1  1-cycle pulse: frame finished with no error
- par_err  out  1  parity error of last finished frame
- stp_err  out  1  stop error of last finished frame
- par_err_cnt  out  CNT_WIDTH  saturating parity error count
- stp_err_cnt  out  CNT_WIDTH  saturating stop error count

## Operation
- States: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE: ignore bit_strb. On frame_start: latch config, clear bit counter, shift register, running parity, par_err and stp_err, then go to DATA.
- DATA: each bit_strb shifts sampled_bit into the MSB of the shift register (LSB-first reassembly) and XORs it into the running parity. After the DATA_WIDTH-th strobe, go to PARITY if par_en, else STOP1.
- PARITY: expected = running parity XOR par_typ. On bit_strb, store mismatch internally and go to STOP1.
- STOP1: on bit_strb, record stop fault if sampled_bit = 0. If stop2, go to STOP2; otherwise finish.
- STOP2: on bit_strb, OR in a fault if sampled_bit = 0, then finish.
- Finish, registered on the same edge:
  - par_err ← parity mismatch (always 0 when par_en = 0)
  - stp_err ← any stop fault
  - frame_done = 1
  - frame_valid = 1 only if both errors are 0; p_data ← shift register only in that case, otherwise held
  - state → IDLE
- Priority: frame_start beats everything. A frame_start in any non-IDLE state aborts the frame (no frame_done) and restarts.
- Finish-edge flag update beats a same-cycle err_clr. err_clr otherwise zeroes both flags.
- Config inputs changing mid-frame have no effect.
- Counters: +1 at finish when the respective error is set. Each saturates at 2^CNT_WIDTH−1 (no wrap). cnt_clr beats a same-cycle increment (result 0).

## Timing
- Reset values: state IDLE; p_data, par_err, stp_err, frame_done, frame_valid and both counters all 0.
- Latency: outputs update on the clock edge that samples the last stop bit_strb. frame_done/frame_valid are high exactly one cycle after that edge.
- Back-to-back frames: frame_start is accepted in the cycle following frame_done.
- Flags hold until the next frame_start, err_clr, or reset.
- Reset asserted mid-frame returns to IDLE immediately; no frame_done is issued.

## Configuration
- UART_FRAME_CHECK_ERR_CNT_EN defined: both counters and their saturation/clear logic are built.
- Not defined: par_err_cnt and stp_err_cnt are tied to 0, cnt_clr is ignored, no counter flops.

## Test plan
- Good frame, DATA_WIDTH=8, data 0xA5, even parity bit 0, one stop = 1 → frame_valid pulse, p_data = 0xA5, par_err = 0, stp_err = 0.
- Odd parity, data 0x01, parity bit sent 0 (expected 0) then data 0x03, parity bit 0 (expected 1) → first frame valid; second frame par_err = 1, no frame_valid, p_data stays 0x01, par_err_cnt = 1.
- stop2 = 1, first stop 1, second stop 0 → stp_err = 1, frame_done only; stop2 = 0 with same bits → valid.
- frame_start after the 4th data strobe → no frame_done; the following full frame 0x3C is reported correctly.
- Same-cycle err_clr and failing final stop strobe → stp_err = 1. err_clr alone afterward → 0.
- With the macro defined and CNT_WIDTH=2, five bad-stop frames → stp_err_cnt = 3 (saturated). cnt_clr with a same-cycle bad frame → 0.
